// File: rtl/aes_out_serializer.sv
// -----------------------------------------------------------------------------
// aes_out_serializer
//
// Downstream stage of the AES-128 core. Each rising edge of aes_valid captures
// one 128-bit ciphertext block into a small block FIFO. The head block is then
// emitted as sixteen bytes over a valid/ready byte stream. The core is never
// stalled. When the FIFO is full, a new block is dropped. Drops are reported
// through a sticky overflow flag and a saturating drop counter.
//
// Parameters
//   DEPTH      number of 128-bit block entries (power of 2, >= 2)
//   MSB_FIRST  1: first byte is bits [127:120]; 0: first byte is bits [7:0]
//
// Ports
//   clk             clock, all state updates on posedge
//   rst             asynchronous active-high reset
//   aes_out_bus     ciphertext from the AES core
//   aes_valid       core output-valid flag (rising edge = one block)
//   m_data          output byte (registered)
//   m_valid         m_data holds a valid byte
//   m_ready         consumer accepts the byte at posedge when m_valid is high
//   m_last          current byte is byte 15 of its block
//   overflow        sticky: at least one block was dropped
//   clear_overflow  synchronous clear of overflow and drop_count
//   drop_count      number of dropped blocks, saturating at 255
//   level           number of occupied block entries (0..DEPTH)
// -----------------------------------------------------------------------------
module aes_out_serializer #(
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [127:0]              aes_out_bus,
  input  logic                      aes_valid,
  output logic [7:0]                m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      overflow,
  input  logic                      clear_overflow,
  output logic [7:0]                drop_count,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [3:0]    LAST_IDX   = 4'd15;
  localparam logic [7:0]    DROP_MAX   = 8'd255;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [127:0]  mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [3:0]    idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_count_q, drop_count_d;
  logic [7:0]    m_data_q, m_data_d;

  // ---------------------------------------------------------------------------
  // Events
  // ---------------------------------------------------------------------------
  logic push_evt;    // rising edge of aes_valid
  logic xfer;        // byte accepted by the consumer
  logic pop;         // last byte of the head block accepted
  logic full;
  logic push_acc;    // block is written into the FIFO
  logic drop;        // block is lost

  logic [127:0] head_blk_d;

  // Select byte number idx of a block, in stream order.
  function automatic logic [7:0] sel_byte(input logic [127:0] blk,
                                          input logic [3:0]   idx);
    logic [3:0] pos;
    pos = MSB_FIRST ? (LAST_IDX - idx) : idx;
    return blk[{pos, 3'b000} +: 8];
  endfunction

  always_comb begin
    push_evt = aes_valid && !valid_q;
    xfer     = (level_q != '0) && m_ready;
    pop      = xfer && (idx_q == LAST_IDX);
    full     = (level_q == FULL_LEVEL);
    // A pop at the same edge frees the entry, so a full FIFO can still
    // accept the new block.
    push_acc = push_evt && (!full || pop);
    drop     = push_evt && full && !pop;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first, so no path through this
    // block can leave one unassigned and infer a latch.
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    idx_d        = idx_q;
    valid_d      = aes_valid;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    head_blk_d   = '0;
    m_data_d     = '0;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (xfer) begin
      idx_d = idx_q + 4'd1;           // wraps 15 -> 0
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push_acc, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // The clear is applied first so that a drop on the same edge
    // is still recorded as overflow=1, drop_count=1.
    if (clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_d != DROP_MAX) begin
        drop_count_d = drop_count_d + 8'd1;
      end
    end

    // Registered head-byte mux. It looks ahead to the head entry after this
    // edge. If that entry is being written at this same edge, it takes the
    // block straight from the bus. This covers an empty FIFO and a pop that
    // drains the last stored block while a new one arrives.
    if (push_acc && (wr_ptr_q == rd_ptr_d)) begin
      head_blk_d = aes_out_bus;
    end else begin
      head_blk_d = mem_q[rd_ptr_d];
    end

    if (level_d != '0) begin
      m_data_d = sel_byte(head_blk_d, idx_d);
    end
  end

  // ---------------------------------------------------------------------------
  // Block storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Its contents are only observed
  // through level/pointers, and those are reset.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= aes_out_bus;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments.
  // All flops then sample the pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      idx_q        <= '0;
      // Start "high" so an aes_valid already asserted through reset is not
      // seen as a rising edge.
      valid_q      <= 1'b1;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      m_data_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      m_data_q     <= m_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registers only
  // ---------------------------------------------------------------------------
  assign m_data     = m_data_q;
  assign m_valid    = (level_q != '0);
  assign m_last     = m_valid && (idx_q == LAST_IDX);
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign level      = level_q;

endmodule

// File: tb/tb_aes_out_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for aes_out_serializer.
//
// Two instances share all inputs. One is built MSB-first and one LSB-first.
// Expected byte streams for both go into per-instance scoreboard queues when a
// block capture is driven. A negedge monitor pops a queue entry on every
// handshake and checks that m_data is held while the consumer stalls.
// -----------------------------------------------------------------------------
module tb_aes_out_serializer;

  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [127:0]  aes_out_bus;
  logic          aes_valid;
  logic          m_ready;
  logic          clear_overflow;

  logic [7:0]    m_data_m,     m_data_l;
  logic          m_valid_m,    m_valid_l;
  logic          m_last_m,     m_last_l;
  logic          overflow_m,   overflow_l;
  logic [7:0]    drop_count_m, drop_count_l;
  logic [LW-1:0] level_m,      level_l;

  aes_out_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .aes_out_bus    (aes_out_bus),
    .aes_valid      (aes_valid),
    .m_data         (m_data_m),
    .m_valid        (m_valid_m),
    .m_ready        (m_ready),
    .m_last         (m_last_m),
    .overflow       (overflow_m),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count_m),
    .level          (level_m)
  );

  aes_out_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk            (clk),
    .rst            (rst),
    .aes_out_bus    (aes_out_bus),
    .aes_valid      (aes_valid),
    .m_data         (m_data_l),
    .m_valid        (m_valid_l),
    .m_ready        (m_ready),
    .m_last         (m_last_l),
    .overflow       (overflow_l),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count_l),
    .level          (level_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard entries: {pad, last, data}. An empty queue yields a sentinel
  // with the pad bit set, which no observed value can match.
  logic [9:0] q_m[$];
  logic [9:0] q_l[$];
  int         xfer_m = 0;
  int         xfer_l = 0;

  localparam logic [9:0] EMPTY_SENTINEL = 10'h3ff;

  localparam logic [127:0] BLK0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_A = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
  localparam logic [127:0] BLK_B = 128'hb0b1b2b3b4b5b6b7b8b9babbbcbdbebf;
  localparam logic [127:0] BLK_C = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;
  localparam logic [127:0] BLK_P = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] BLK_Q = 128'h123456789abcdef00fedcba987654321;
  localparam logic [127:0] BLK_R = 128'hdeadbeefcafef00d0123456789abcdef;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return 1 ns after it, where inputs are driven.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected byte order is worked out from the block, independently of the DUT.
  task automatic push_exp(input logic [127:0] b);
    for (int i = 0; i < 16; i++) begin
      q_m.push_back({1'b0, (i == 15), b[127 - 8*i -: 8]});
      q_l.push_back({1'b0, (i == 15), b[8*i +: 8]});
    end
  endtask

  // One-cycle aes_valid pulse, then one low cycle so the next pulse is an edge.
  task automatic capture(input logic [127:0] b, input bit accepted);
    aes_out_bus = b;
    if (accepted) push_exp(b);
    aes_valid = 1'b1;
    tick(1);
    aes_valid = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 100; c++) begin
      if (q_m.size() == 0 && q_l.size() == 0 && !m_valid_m && !m_valid_l) break;
      tick(1);
    end
    check({tag, "_sb_left"}, 32'(q_m.size() + q_l.size()), 32'd0);
    check({tag, "_valid"}, 32'({m_valid_m, m_valid_l}), 32'd0);
    check({tag, "_level"}, 32'(level_m), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor and hold-stability check
  // ---------------------------------------------------------------------------
  logic       hold_m = 1'b0, hold_l = 1'b0;
  logic [8:0] held_m, held_l;

  always @(negedge clk) begin
    if (rst) begin
      hold_m = 1'b0;
      hold_l = 1'b0;
    end else begin
      if (hold_m) check("hold_msb", 32'({m_valid_m, m_last_m, m_data_m}),
                        32'({1'b1, held_m}));
      if (hold_l) check("hold_lsb", 32'({m_valid_l, m_last_l, m_data_l}),
                        32'({1'b1, held_l}));
      if (m_valid_m && m_ready) begin
        check("byte_msb", 32'({1'b0, m_last_m, m_data_m}),
              32'((q_m.size() != 0) ? q_m.pop_front() : EMPTY_SENTINEL));
        xfer_m++;
      end
      if (m_valid_l && m_ready) begin
        check("byte_lsb", 32'({1'b0, m_last_l, m_data_l}),
              32'((q_l.size() != 0) ? q_l.pop_front() : EMPTY_SENTINEL));
        xfer_l++;
      end
      hold_m = m_valid_m && !m_ready;
      hold_l = m_valid_l && !m_ready;
      held_m = {m_last_m, m_data_m};
      held_l = {m_last_l, m_data_l};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst            = 1'b1;
    aes_valid      = 1'b1;      // held high through reset
    aes_out_bus    = BLK_C;
    m_ready        = 1'b1;
    clear_overflow = 1'b0;

    // Reset state
    #3;
    check("rst_level",    32'(level_m),      32'd0);
    check("rst_valid",    32'({m_valid_m, m_valid_l}), 32'd0);
    check("rst_last",     32'({m_last_m, m_last_l}),   32'd0);
    check("rst_data",     32'(m_data_m),     32'd0);
    check("rst_overflow", 32'(overflow_m),   32'd0);
    check("rst_drops",    32'(drop_count_m), 32'd0);
    tick(3);
    rst = 1'b0;

    // aes_valid held high since reset: nothing is captured
    tick(10);
    check("held_no_capture_level", 32'(level_m), 32'd0);
    check("held_no_capture_valid", 32'(m_valid_m), 32'd0);
    aes_valid = 1'b0;
    tick(2);

    // Single block with a 3-cycle pulse; m_ready high throughout
    xfer_m = 0;
    xfer_l = 0;
    aes_out_bus = BLK0;
    push_exp(BLK0);
    aes_valid = 1'b1;
    tick(1);
    check("latency_valid", 32'({m_valid_m, m_valid_l}), 32'h3);
    check("latency_level", 32'(level_m), 32'd1);
    check("first_byte_msb", 32'(m_data_m), 32'h00);
    check("first_byte_lsb", 32'(m_data_l), 32'hff);
    tick(2);
    aes_valid = 1'b0;
    drain("single");
    check("single_xfers", 32'(xfer_m + xfer_l), 32'd32);

    // Backpressure: m_ready follows 1,0,0,1,...
    xfer_m = 0;
    xfer_l = 0;
    m_ready = 1'b0;
    capture(BLK0, 1'b1);
    begin
      logic [3:0] pat;
      pat = 4'b1001;
      for (int c = 0; c < 200; c++) begin
        if (q_m.size() == 0 && !m_valid_m) break;
        m_ready = pat[c % 4];
        tick(1);
      end
    end
    m_ready = 1'b1;
    drain("backpressure");
    check("bp_xfers_msb", 32'(xfer_m), 32'd16);
    check("bp_xfers_lsb", 32'(xfer_l), 32'd16);

    // Overflow: A and B fit, C is dropped
    m_ready = 1'b0;
    capture(BLK_A, 1'b1);
    capture(BLK_B, 1'b1);
    capture(BLK_C, 1'b0);
    check("ovf_level",    32'(level_m),      32'd2);
    check("ovf_flag",     32'({overflow_m, overflow_l}), 32'h3);
    check("ovf_drops",    32'(drop_count_m), 32'd1);
    check("ovf_drops_lsb", 32'(drop_count_l), 32'd1);
    m_ready = 1'b1;
    drain("ovf_drain");
    check("ovf_flag_sticky", 32'(overflow_m), 32'd1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("clr_flag",  32'(overflow_m),   32'd0);
    check("clr_drops", 32'(drop_count_m), 32'd0);

    // Two drops, then a clear coinciding with a third drop
    m_ready = 1'b0;
    capture(BLK_P, 1'b1);
    capture(BLK_Q, 1'b1);
    capture(BLK_A, 1'b0);
    capture(BLK_B, 1'b0);
    check("two_drops", 32'(drop_count_m), 32'd2);
    aes_out_bus    = BLK_C;
    aes_valid      = 1'b1;
    clear_overflow = 1'b1;
    tick(1);
    aes_valid      = 1'b0;
    clear_overflow = 1'b0;
    check("clr_and_drop_flag",  32'(overflow_m),   32'd1);
    check("clr_and_drop_count", 32'(drop_count_m), 32'd1);
    check("clr_and_drop_level", 32'(level_m),      32'd2);
    m_ready = 1'b1;
    drain("clr_drop_drain");
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;

    // Full FIFO, push on the same edge as the head block's last byte
    m_ready = 1'b0;
    capture(BLK_P, 1'b1);
    capture(BLK_Q, 1'b1);
    check("full_level", 32'(level_m), 32'd2);
    m_ready = 1'b1;
    tick(15);
    check("full_at_last", 32'({m_last_m, m_last_l}), 32'h3);
    aes_out_bus = BLK_R;
    push_exp(BLK_R);
    aes_valid = 1'b1;
    tick(1);
    aes_valid = 1'b0;
    check("full_pop_level",    32'(level_m),    32'd2);
    check("full_pop_overflow", 32'(overflow_m), 32'd0);
    check("full_pop_next_msb", 32'(m_data_m),   32'(BLK_Q[127:120]));
    check("full_pop_next_lsb", 32'(m_data_l),   32'(BLK_Q[7:0]));
    drain("full_pop_drain");

    // Reset in the middle of a block discards it at once
    m_ready = 1'b0;
    capture(BLK_A, 1'b0);
    tick(3);
    check("mid_valid_before", 32'(m_valid_m), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'({m_valid_m, m_valid_l}), 32'd0);
    check("mid_rst_level", 32'(level_m), 32'd0);
    check("mid_rst_data",  32'(m_data_m), 32'd0);
    tick(2);
    rst = 1'b0;
    m_ready = 1'b1;
    tick(4);
    check("after_rst_idle", 32'({m_valid_m, m_valid_l}), 32'd0);
    check("final_sb_empty", 32'(q_m.size() + q_l.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Downstream stage of the AES-128 core. Captures each 128-bit ciphertext block when the core flags its output valid.
- Buffers captured blocks in a small block FIFO and emits them as an 8-bit byte stream with a valid/ready handshake, most-significant byte first.
- Detects and counts blocks lost when the buffer is full.

Parameters:
DEPTH, 2, number of 128-bit block entries in the FIFO (power of 2, min 2)
MSB_FIRST, 1, 1: first byte out is bits [127:120]; 0: first byte out is bits [7:0]

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
aes_out_bus  input  128  ciphertext from the AES core
aes_valid  input  1  core output-valid flag
m_data  output  8  output byte
m_valid  output  1  m_data holds a valid byte
m_ready  input  1  consumer accepts byte when m_valid && m_ready at posedge
m_last  output  1  current byte is byte 15 of its block
overflow  output  1  sticky: at least one block dropped
clear_overflow  input  1  synchronous clear of overflow and drop_count
drop_count  output  8  number of dropped blocks, saturates at 255
level  output  $clog2(DEPTH)+1  number of occupied block entries

Behaviour:
- Reset (async, rst=1):
  - FIFO empty, level=0, byte index=0.
  - m_valid=0, m_last=0, m_data=0.
  - overflow=0, drop_count=0.
  - Edge-detect register valid_q=1, so an aes_valid held high through reset is not captured.
- Capture:
  - A push event occurs at posedge when aes_valid=1 and valid_q=0 (rising edge).
  - valid_q <= aes_valid every cycle.
  - aes_valid held high for many cycles produces exactly one push.
  - The push writes aes_out_bus sampled at that same edge.
- Push latency: the block written at edge N drives m_valid=1 from the cycle after edge N (registered status), provided the FIFO was empty.
- Output:
  - m_valid = (level != 0).
  - m_data = byte idx of the head entry, where idx is 0..15.
  - MSB_FIRST=1 selects bits [127-8*idx -: 8]; MSB_FIRST=0 selects bits [8*idx +: 8].
  - m_data, m_valid and m_last are driven from registers or the FIFO read port, with no combinational path from m_ready or aes_*.
  - Recommended: a registered head-byte mux.
- Handshake:
  - On m_valid && m_ready: idx increments. If idx==15, idx wraps to 0 and the head entry pops.
  - m_last = m_valid && (idx==15).
  - m_data is held stable while m_valid && !m_ready.
- Full/overflow:
  - If a push event occurs with level==DEPTH and no pop at the same edge, the block is dropped and the FIFO is unchanged.
  - On a drop: overflow <= 1, and drop_count increments unless already 255.
- Simultaneous push and pop:
  - With level==DEPTH: the pop frees an entry, the push is accepted, and level is unchanged.
  - With level==0: push only.
- clear_overflow:
  - Clears overflow and drop_count at the edge.
  - If a drop occurs at the same edge, the result is overflow=1, drop_count=1.
- Write/read pointers: wrap modulo DEPTH. level is tracked separately, covering 0..DEPTH.
- Reset mid-block: idx and all contents are discarded immediately; m_valid drops asynchronously.
- No backpressure to the core: the core is never stalled; loss is reported only through overflow/drop_count.

Test Plan:
- Single block:
  - Stimulus: after reset, aes_out_bus=128'h00112233445566778899aabbccddeeff; one aes_valid pulse; m_ready=1 throughout.
  - Required response: 16 consecutive bytes 00,11,...,ff. m_last only on ff. m_valid=0 afterwards, level=0.
- Backpressure:
  - Stimulus: same block, m_ready toggled 1,0,0,1,...
  - Required response: each byte held stable while m_ready=0, no byte skipped or duplicated, 16 transfers total.
- Held valid / reset capture:
  - Stimulus: aes_valid=1 during and after reset for 10 cycles, then 0, then a 3-cycle high pulse.
  - Required response: nothing captured during the initial high; exactly one block captured on the later pulse.
- Overflow (DEPTH=2):
  - Stimulus: m_ready=0; three capture events with blocks A, B, C.
  - Required response: level=2, overflow=1, drop_count=1. Releasing m_ready emits A then B; C is never emitted.
  - Then: clear_overflow pulse -> overflow=0, drop_count=0.
- Full with simultaneous pop:
  - Stimulus: level=2, head at idx=15, m_ready=1, and a push event on the same edge.
  - Required response: push accepted, level stays 2, overflow stays 0, next byte is byte 0 of the second block.
- MSB_FIRST=0 build:
  - Stimulus: block 128'h00112233445566778899aabbccddeeff.
  - Required response: bytes ff,ee,...,00, with m_last on 00.
